// File: rtl/alu_exec_ctrl.sv
// Single-issue execute controller feeding an 8-bit ALU: IDLE -> EXEC -> WB per instruction.
// Optional immediate operand path enabled by defining ALU_EXEC_IMM_EN.
module alu_exec_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  input  logic [7:0] imm_data,
  output logic       instr_ready,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_res,
  input  logic       alu_c_out,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic [2:0] flags,
  output logic       done,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic [1:0] dst_q, dst_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [7:0] res_q, res_d;
  logic [2:0] flg_q, flg_d;
  logic [2:0] flags_q, flags_d;
  logic       done_q, done_d;

  logic [2:0] instr_op;
  logic [1:0] instr_dst;
  logic [1:0] instr_src;
  logic [7:0] opnd_b;
  logic       accept;

  assign instr_op  = instr[7:5];
  assign instr_dst = instr[4:3];
  assign instr_src = instr[2:1];

`ifdef ALU_EXEC_IMM_EN
  assign opnd_b = instr[0] ? imm_data : regs_q[instr_src];
`else
  logic unused_imm;
  assign opnd_b     = regs_q[instr_src];
  assign unused_imm = ^{instr[0], imm_data};
`endif

  // Preload owns the IDLE cycle; ready also drops while reset is held.
  assign instr_ready = !rst && (state_q == ST_IDLE) && !wr_en;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    flg_d    = flg_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dst_d    = instr_dst;
          alu_a_d  = regs_q[instr_dst];
          alu_b_d  = opnd_b;
          alu_op_d = instr_op;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_res;
        flg_d   = {alu_c_out, alu_zero, alu_ovf};
        done_d  = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        flags_d = flg_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (state_q == ST_IDLE && wr_en) begin
      regs_d[wr_sel] = wr_data;
    end else if (state_q == ST_WB) begin
      regs_d[dst_q] = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dst_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      flg_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      for (int unsigned i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign flags    = flags_q;
  assign done     = done_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized self-checking bench for alu_exec_ctrl with a behavioural ALU attached.
// Honours ALU_EXEC_IMM_EN the same way the design does.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] imm_data;
  logic       instr_ready;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_c_out, alu_zero, alu_ovf;
  logic [2:0] flags;
  logic       done;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] ref_r [4];
  logic [2:0] ref_flags;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .imm_data(imm_data),
    .instr_ready(instr_ready),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_c_out(alu_c_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .flags(flags), .done(done),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // ALU op map: AND OR XOR INV ADD SUB INC DEC; returns {c, z, v, res}
  function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic       v;
    w = '0;
    v = 1'b0;
    case (op)
      3'd0: w = {1'b0, a & b};
      3'd1: w = {1'b0, a | b};
      3'd2: w = {1'b0, a ^ b};
      3'd3: w = {1'b0, ~a};
      3'd4: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
      3'd5: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
      3'd6: begin w = {1'b0, a} + 9'd1; v = (a == 8'h7F); end
      default: begin w = {1'b0, a} - 9'd1; v = (a == 8'h80); end
    endcase
    return {w[8], (w[7:0] == 8'h00), v, w[7:0]};
  endfunction

  always_comb begin
    logic [10:0] o;
    o = alu_fn(alu_op, alu_a, alu_b);
    alu_res   = o[7:0];
    alu_c_out = o[10];
    alu_zero  = o[9];
    alu_ovf   = o[8];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] s, output logic [7:0] v);
    dbg_sel = s;
    #1;
    v = dbg_data;
  endtask

  task automatic check_all_regs(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      check_eq(tag, {24'd0, v}, {24'd0, ref_r[i]});
    end
    check_eq({tag, "_flags"}, {29'd0, flags}, {29'd0, ref_flags});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_ready_low", {31'd0, instr_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_flags = 3'b000;
    #1;
    check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check_eq("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check_eq("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check_all_regs("rst_reg");
  endtask

  task automatic preload(input logic [1:0] sel, input logic [7:0] data);
    logic [7:0] v;
    wr_en = 1'b1;
    wr_sel = sel;
    wr_data = data;
    tick();
    wr_en = 1'b0;
    ref_r[sel] = data;
    read_reg(sel, v);
    check_eq("preload", {24'd0, v}, {24'd0, data});
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                           input logic isel, input logic [7:0] imm, input bit junk_wr);
    logic [7:0]  a, b, v;
    logic [10:0] o;
    int unsigned waited;
    a = ref_r[dst];
`ifdef ALU_EXEC_IMM_EN
    b = isel ? imm : ref_r[src];
`else
    b = ref_r[src];
`endif
    o = alu_fn(op, a, b);
    instr = {op, dst, src, isel};
    imm_data = imm;
    instr_valid = 1'b1;
    #1;
    waited = 0;
    while (!instr_ready && waited < 10) begin
      tick();
      waited++;
    end
    check_eq("accept_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    instr = 8'($urandom);
    imm_data = 8'($urandom);
    if (junk_wr) begin
      wr_en = 1'b1;
      wr_sel = 2'($urandom);
      wr_data = 8'($urandom);
    end
    #1;
    check_eq("exec_ready", {31'd0, instr_ready}, 32'd0);
    check_eq("exec_done", {31'd0, done}, 32'd0);
    check_eq("exec_alu_a", {24'd0, alu_a}, {24'd0, a});
    check_eq("exec_alu_b", {24'd0, alu_b}, {24'd0, b});
    check_eq("exec_alu_op", {29'd0, alu_op}, {29'd0, op});
    tick();
    check_eq("wb_done", {31'd0, done}, 32'd1);
    check_eq("wb_ready", {31'd0, instr_ready}, 32'd0);
    check_eq("wb_flags_old", {29'd0, flags}, {29'd0, ref_flags});
    tick();
    wr_en = 1'b0;
    ref_r[dst] = o[7:0];
    ref_flags = o[10:8];
    read_reg(dst, v);
    check_eq("idle_done", {31'd0, done}, 32'd0);
    check_eq("idle_ready", {31'd0, instr_ready}, 32'd1);
    check_eq("wb_result", {24'd0, v}, {24'd0, o[7:0]});
    check_eq("wb_flags", {29'd0, flags}, {29'd0, o[10:8]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  v;
    logic [10:0] o;
    int unsigned n_acc, t0, t1;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    imm_data = '0;
    wr_en = 1'b0;
    wr_sel = '0;
    wr_data = '0;
    dbg_sel = '0;
    tick();
    do_reset();

    // ADD with signed overflow: 0x7F + 0x01
    preload(2'd1, 8'h7F);
    preload(2'd2, 8'h01);
    run_instr(3'd4, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0);
    read_reg(2'd1, v);
    check_eq("add_r1", {24'd0, v}, 32'h80);
    check_eq("add_flags", {29'd0, flags}, 32'b001);

    // SUB to zero
    preload(2'd0, 8'h10);
    preload(2'd3, 8'h10);
    run_instr(3'd5, 2'd0, 2'd3, 1'b0, 8'h00, 1'b0);
    read_reg(2'd0, v);
    check_eq("sub_r0", {24'd0, v}, 32'h00);
    check_eq("sub_flags", {29'd0, flags}, 32'b010);

    // XOR with immediate, src == dst
    preload(2'd2, 8'h00);
    run_instr(3'd2, 2'd2, 2'd2, 1'b1, 8'h5A, 1'b0);
    read_reg(2'd2, v);
`ifdef ALU_EXEC_IMM_EN
    check_eq("imm_r2", {24'd0, v}, 32'h5A);
`else
    check_eq("imm_r2", {24'd0, v}, 32'h00);
`endif

    // Back-to-back INC R0 held valid
    do_reset();
    instr = {3'd6, 2'd0, 2'd0, 1'b0};
    instr_valid = 1'b1;
    #1;
    n_acc = 0; t0 = 0; t1 = 0;
    for (int cyc = 0; cyc < 20 && n_acc < 2; cyc++) begin
      if (instr_ready) begin
        if (n_acc == 0) t0 = cyc; else t1 = cyc;
        tick();
        n_acc++;
        if (n_acc == 2) instr_valid = 1'b0;
        check_eq("b2b_opnd", {24'd0, alu_a}, n_acc - 1);
      end else begin
        tick();
      end
    end
    check_eq("b2b_accepts", n_acc, 32'd2);
    check_eq("b2b_gap", t1 - t0, 32'd3);
    tick();
    check_eq("b2b_done", {31'd0, done}, 32'd1);
    tick();
    o = alu_fn(3'd6, 8'h01, 8'h01);
    ref_r[0] = 8'h02;
    ref_flags = o[10:8];
    read_reg(2'd0, v);
    check_eq("b2b_r0", {24'd0, v}, 32'h02);
    check_all_regs("b2b_reg");

    // Reset during EXEC aborts the instruction
    preload(2'd1, 8'h33);
    instr = {3'd7, 2'd1, 2'd1, 1'b0};
    instr_valid = 1'b1;
    #1;
    check_eq("abort_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("abort_done_rst", {31'd0, done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_flags = 3'b000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("abort_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    read_reg(2'd1, v);
    check_eq("abort_r1", {24'd0, v}, 32'h00);
    check_all_regs("abort_reg");

    // Random traffic
    for (int iter = 0; iter < 150; iter++) begin
      case ($urandom_range(0, 3))
        0: preload(2'($urandom), 8'($urandom));
        1: begin
          wr_en = 1'b1;
          wr_sel = 2'($urandom);
          wr_data = 8'($urandom);
          instr_valid = 1'b1;
          instr = 8'($urandom);
          #1;
          check_eq("pre_blocks", {31'd0, instr_ready}, 32'd0);
          tick();
          ref_r[wr_sel] = wr_data;
          wr_en = 1'b0;
          instr_valid = 1'b0;
          #1;
          check_eq("pre_no_accept", {31'd0, instr_ready}, 32'd1);
          run_instr(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 1'b0);
        end
        default: run_instr(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                           8'($urandom), 1'($urandom));
      endcase
      if (iter % 10 == 9) check_all_regs("rand_reg");
    end
    check_all_regs("final_reg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
